// File: rtl/alu_pkg.sv
// Shared constants for the wide ALU sequencer: op codes, status bit positions, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // ALU select codes understood by the external 32-bit ALU.
    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ZERO = 3'b111;

    // Status vector bit positions, vector is {N,Z,V,C}.
    localparam int ST_C = 0;
    localparam int ST_V = 1;
    localparam int ST_Z = 2;
    localparam int ST_N = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Shift codes (101/110) cannot be split into independent halves, so they are rejected.
    function automatic logic op_supported(input logic [2:0] op);
        return op inside {OP_XOR, OP_AND, OP_OR, OP_NOR, OP_ADD, OP_ZERO};
    endfunction

endpackage

// File: rtl/alu_wide_sequencer.sv
// Runs 64-bit logic/add ops as two passes (low, high) over an external combinational 32-bit ALU.
// Latency: rsp_valid 3 cycles after accept for supported ops, 1 cycle for rejected op codes.
// Backpressure: response held stable in DONE until rsp_ready; cmd_ready only in IDLE, one op in flight.
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int OP_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [63:0]         cmd_a,
    input  logic [63:0]         cmd_b,
    input  logic                cmd_cin,

    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic                alu_cin,
    output logic [2:0]          alu_sel,
    input  logic [31:0]         alu_out,
    input  logic [3:0]          alu_status,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [63:0]         rsp_data,
    output logic [3:0]          rsp_status,
    output logic                rsp_err,
    output logic [OP_CNT_W-1:0] op_count
);

    seq_state_t  state;
    seq_state_t  state_nxt;

    logic [2:0]  op_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        cin_q;
    logic [31:0] lo_q;
    logic        carry_q;
    logic        init_done;

    logic        cmd_fire;
    logic        rsp_fire;
    logic        is_add;
    logic [3:0]  hi_status;

    // The ALU's own N/Z describe only one half; full-width N/Z are rebuilt locally.
    logic        unused_alu_nz;
    assign unused_alu_nz = ^alu_status[ST_N:ST_Z];

    // cmd_ready stays low through reset and rises only after the first clock edge following release.
    assign cmd_ready = (state == S_IDLE) && init_done;
    assign rsp_valid = (state == S_DONE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign is_add    = (op_q == OP_ADD);

    // Marks that at least one clock edge has passed since reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: rejected op codes skip both ALU passes.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = op_supported(cmd_op) ? S_LO : S_DONE;
                end
            end
            S_LO:   state_nxt = S_HI;
            S_HI:   state_nxt = S_DONE;
            S_DONE: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU operand steering; the ALU sees ZERO with null operands whenever no pass is running.
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_cin = 1'b0;
        alu_sel = OP_ZERO;
        case (state)
            S_LO: begin
                alu_a   = a_q[31:0];
                alu_b   = b_q[31:0];
                alu_sel = op_q;
                alu_cin = is_add & cin_q;
            end
            S_HI: begin
                alu_a   = a_q[63:32];
                alu_b   = b_q[63:32];
                alu_sel = op_q;
                alu_cin = is_add & carry_q;
            end
            default: ;
        endcase
    end

    // Full-width status from the high pass: C/V only meaningful for ADD, Z spans both halves.
    always_comb begin
        hi_status       = 4'd0;
        hi_status[ST_C] = is_add & alu_status[ST_C];
        hi_status[ST_V] = is_add & alu_status[ST_V];
        hi_status[ST_Z] = (alu_out == 32'd0) && (lo_q == 32'd0);
        hi_status[ST_N] = alu_out[31];
    end

    // Command capture and per-pass result capture; inputs are not looked at again after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ZERO;
            a_q        <= 64'd0;
            b_q        <= 64'd0;
            cin_q      <= 1'b0;
            lo_q       <= 32'd0;
            carry_q    <= 1'b0;
            rsp_data   <= 64'd0;
            rsp_status <= 4'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q  <= cmd_op;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                cin_q <= cmd_cin;
                if (!op_supported(cmd_op)) begin
                    rsp_data   <= 64'd0;
                    rsp_status <= 4'd0;
                    rsp_err    <= 1'b1;
                end
            end
            if (state == S_LO) begin
                lo_q    <= alu_out;
                carry_q <= alu_status[ST_C];
            end
            if (state == S_HI) begin
                rsp_data   <= {alu_out, lo_q};
                rsp_status <= hi_status;
                rsp_err    <= 1'b0;
            end
        end
    end

    // Completed-response counter, error responses included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + OP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer with a behavioural 32-bit ALU and a 64-bit reference scoreboard.
// Latency: checks 3-cycle (supported) and 1-cycle (rejected) response timing.
// Backpressure: holds rsp_ready low for several cycles and checks response stability.
module tb_alu_wide_sequencer;

    // Narrow counter so the wrap-to-zero case is reachable in a short run.
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [63:0]   cmd_a;
    logic [63:0]   cmd_b;
    logic          cmd_cin;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic          alu_cin;
    logic [2:0]    alu_sel;
    logic [31:0]   alu_out;
    logic [3:0]    alu_status;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_data;
    logic [3:0]    rsp_status;
    logic          rsp_err;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  st;
        logic        err;
        int          lat;
    } exp_t;

    exp_t          sb_q[$];
    int            n_chk;
    int            n_bad;
    logic [CW-1:0] exp_cnt;

    alu_wide_sequencer #(.OP_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational 32-bit ALU, status {N,Z,V,C}.
    logic [32:0] alu_sum;
    logic        alu_v;
    logic        alu_c;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (alu_sel)
            3'b000: alu_out = alu_a ^ alu_b;
            3'b001: alu_out = alu_a & alu_b;
            3'b010: alu_out = alu_a | alu_b;
            3'b011: alu_out = ~(alu_a | alu_b);
            3'b100: begin
                alu_out = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            default: alu_out = 32'd0;
        endcase
        alu_status = {alu_out[31], alu_out == 32'd0, alu_v, alu_c};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Whole-word 64-bit reference, independent of the two-pass split.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [63:0] a,
                                       input logic [63:0] b, input logic cin);
        exp_t        e;
        logic [64:0] s;
        logic [63:0] r;
        logic        c;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        r = 64'd0;
        c = 1'b0;
        v = 1'b0;
        e.err = 1'b0;
        e.lat = 3;
        case (op)
            3'b000: r = a ^ b;
            3'b001: r = a & b;
            3'b010: r = a | b;
            3'b011: r = ~(a | b);
            3'b100: begin
                r = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b111: r = 64'd0;
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        e.data = r;
        e.st   = e.err ? 4'd0 : {r[63], r == 64'd0, v, c};
        return e;
    endfunction

    // Issues one command from a negedge, then checks passes, latency, hold and handshake.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input int hold);
        exp_t e;
        exp_t g;
        int   lat;
        e = ref_model(op, a, b, cin);
        sb_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        lat = 0;
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("accept_rdy", cmd_ready, 1);
        @(negedge clk);
        // Scramble the command bus; the DUT must use its registered copy.
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_a     = ~a;
        cmd_b     = ~b;
        cmd_cin   = ~cin;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (lat == 1) begin
                check("lo_sel", alu_sel, op);
                check("lo_a", alu_a, a[31:0]);
                check("lo_b", alu_b, b[31:0]);
                check("lo_cin", alu_cin, (op == 3'b100) ? cin : 1'b0);
            end
            if (lat == 2) begin
                check("hi_sel", alu_sel, op);
                check("hi_a", alu_a, a[63:32]);
                check("hi_b", alu_b, b[63:32]);
            end
            check("busy_rdy", cmd_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e.lat);
        for (int i = 0; i < hold; i++) begin
            check("hold_vld", rsp_valid, 1);
            check("hold_rdy", cmd_ready, 0);
            check("hold_data", rsp_data, e.data);
            check("hold_st", rsp_status, e.st);
            check("hold_cnt", op_count, exp_cnt);
            @(negedge clk);
        end
        check("done_sel", alu_sel, 3'b111);
        check("done_a", alu_a, 0);
        check("done_rdy", cmd_ready, 0);
        rsp_ready = 1'b1;
        g = sb_q.pop_front();
        check("rsp_data", rsp_data, g.data);
        check("rsp_status", rsp_status, g.st);
        check("rsp_err", rsp_err, g.err);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        check("op_count", op_count, exp_cnt);
        check("vld_drop", rsp_valid, 0);
        check("idle_rdy", cmd_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"}, rsp_valid, 0);
        check({tag, "_rdy"}, cmd_ready, 0);
        check({tag, "_data"}, rsp_data, 0);
        check({tag, "_st"}, rsp_status, 0);
        check({tag, "_err"}, rsp_err, 0);
        check({tag, "_cnt"}, op_count, 0);
        check({tag, "_sel"}, alu_sel, 3'b111);
        check({tag, "_a"}, alu_a, 0);
        check({tag, "_b"}, alu_b, 0);
        check({tag, "_cin"}, alu_cin, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 64'd0;
        cmd_b     = 64'd0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;

        #3;
        check_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rdy_pre_edge", cmd_ready, 0);
        @(negedge clk);
        check("rel_rdy", cmd_ready, 1);

        // Carry across the half boundary, signed overflow, full carry-out.
        run_op(3'b100, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 0);
        run_op(3'b100, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
        run_op(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
        // Zero detection must span both halves.
        run_op(3'b000, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
        run_op(3'b000, 64'h0000_0001_0000_0000, 64'h0, 1'b1, 0);
        run_op(3'b001, 64'hF0F0_1234_FFFF_0000, 64'hFF00_FFFF_0F0F_FFFF, 1'b1, 0);
        run_op(3'b010, 64'h8000_0000_0000_0001, 64'h0000_0001_8000_0000, 1'b0, 2);
        run_op(3'b011, 64'h0000_0000_0000_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 0);
        run_op(3'b111, 64'hDEAD_BEEF_CAFE_F00D, 64'h1, 1'b1, 0);
        // Rejected op codes, one under extended backpressure.
        run_op(3'b101, 64'hAAAA_5555_AAAA_5555, 64'h3, 1'b1, 5);
        run_op(3'b110, 64'h1, 64'h1, 1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            run_op(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        // Leave a nonzero result registered before the mid-operation reset.
        run_op(3'b010, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0);

        // Abandon an operation during its high pass.
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_a     = 64'h0000_0005_0000_0007;
        cmd_b     = 64'h0000_0009_0000_000B;
        cmd_cin   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_hi", alu_a, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        #1;
        check("rel2_rdy_pre_edge", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end
        check("abort_cnt", op_count, 0);
        run_op(3'b100, 64'h0000_0005_0000_0007, 64'h0000_0009_FFFF_FFFF, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
